popcount_scheduler: RTL and testbench
=====================================

# popcount_scheduler

Round-robin scheduler that shares one serial ones-counter engine (32-bit operand, 6-bit count, `load`/`done` handshake, one bit per clock) between R requesters. It arbitrates among pending requests, loads the winner's operand into the engine, waits for completion with a watchdog, and returns the count tagged with the requester ID. It sits between the requesting blocks and the counter engine, and is the only block that drives the engine's `load` and `data_in`.

## Interface
- R, 4: number of requesters (2..16).
- ID_W, clog2(R) (minimum 1): width of `res_id`.
- ENGINE_N, 32: engine cycles per operation (operand width).
- TIMEOUT, 64: maximum WAIT cycles before the job is aborted; must be greater than ENGINE_N+1.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  R  per-requester request level; held high with data stable until the matching `gnt`.
- req_data  in  32*R  operand of requester i on bits [32*i+31:32*i].
- gnt  out  R  one-hot, single-cycle pulse; the operand is consumed in that cycle.
- cnt_load  out  1  load strobe to the engine.
- cnt_data  out  32  operand to the engine.
- cnt_count  in  6  engine result.
- cnt_done  in  1  engine completion level.
- res_valid  out  1  single-cycle result strobe.
- res_id  out  ID_W  index of the served requester.
- res_count  out  6  number of ones in the operand; 0 on timeout.
- res_timeout  out  1  qualifies `res_valid`: job aborted by the watchdog.
- busy  out  1  high in every state except IDLE.

## Operation
- States: FLUSH, IDLE, LOAD, WAIT, RESP.
- Reset (asynchronous, any state, mid-job included):
  - enter FLUSH; pointer `ptr` = 0; all outputs 0; `cnt_data` = 0.
  - The engine has no reset, so FLUSH holds for ENGINE_N+2 cycles to let any in-flight engine job drain, then moves to IDLE.
- IDLE:
  - If `req` ≠ 0, the winner is the first set bit searching ptr, ptr+1, …, R-1, 0, …, ptr-1.
  - Latch the winner's index and 32-bit operand, then go to LOAD.
  - If `req` = 0, stay in IDLE.
- LOAD (exactly 1 cycle):
  - `cnt_load` = 1, `cnt_data` = latched operand, `gnt[winner]` = 1.
  - Go to WAIT and clear the watchdog counter.
- WAIT:
  - `cnt_load` = 0; the watchdog increments each cycle.
  - If `cnt_done` = 1, capture `cnt_count` and go to RESP.
  - Else, if the watchdog reaches TIMEOUT, set the timeout flag, use count 0, and go to RESP.
  - If `cnt_done` and the timeout occur in the same cycle, `cnt_done` wins.
- RESP (exactly 1 cycle):
  - `res_valid` = 1 with `res_id`, `res_count` and `res_timeout` driven.
  - `ptr` = (winner+1) mod R; wraps from R-1 to 0, including non-power-of-2 R. The pointer also advances on timeout.
  - Go to IDLE.
- `res_id`, `res_count` and `res_timeout` are registered; they hold their last values when `res_valid` = 0.
- A request that drops before `gnt` was not latched. A request that drops after the IDLE sample is still served with the latched operand.
- Simultaneous requests: exactly one `gnt` per job; no requester waits more than R-1 jobs.
- `req` changes outside IDLE are ignored until the next IDLE cycle.

## Timing
- Let edge 0 be the edge at which IDLE samples `req` ≠ 0.
  - LOAD occupies the cycle after edge 0; edge 1 is the engine's load edge.
  - `cnt_done` is high after edge 1+ENGINE_N.
  - RESP is entered at edge ENGINE_N+2, so `res_valid` is high in the cycle after edge 34 (ENGINE_N = 32).
  - IDLE resumes at edge ENGINE_N+3.
- Job pitch with back-to-back requests: ENGINE_N+4 = 36 cycles.
- A stale `cnt_done` = 1 from the previous job is never seen: the engine clears `done` on the load edge, before WAIT samples it.
- After reset release, `busy` = 1 and no `gnt` is issued for ENGINE_N+2 cycles.

## Test plan
- Single request: req = 4'b0001, operand 32'hFFFF_0000, edge 0 → `gnt` = 0001 for 1 cycle, `cnt_load` for 1 cycle; `res_valid` after edge 34 with `res_id` = 0, `res_count` = 16, `res_timeout` = 0.
- Contention and fairness: all four requesters held high with operands 0, 1, 32'h8000_0001 and 32'hFFFF_FFFF → grants in order 0, 1, 2, 3, 0; counts 0, 1, 2, 32; jobs start 36 cycles apart.
- Pointer wrap: after serving requester 3, req = 4'b1001 → requester 0 is granted, not 3.
- Watchdog: stub engine with `cnt_done` stuck at 0 → `res_valid` with `res_timeout` = 1 and `res_count` = 0 after TIMEOUT WAIT cycles; the next job is accepted.
- Reset mid-WAIT: assert `rst_n` = 0 at job cycle 10 → outputs 0 immediately, FLUSH for 34 cycles, then a new request completes with the correct count and no stale result.
- Edge operands: 32'h0000_0000 → 0 and 32'hFFFF_FFFF → 32 back-to-back from requester 2; `res_id` = 2 for both.

Source files
------------

// File: rtl/popcount_scheduler.sv
// rtl/popcount_scheduler.sv - round-robin scheduler sharing one serial popcount engine among R requesters
module popcount_scheduler #(
    parameter int R        = 4,
    parameter int ID_W     = (R > 1) ? $clog2(R) : 1,
    parameter int ENGINE_N = 32,
    parameter int TIMEOUT  = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [R-1:0]    req,
    input  logic [32*R-1:0] req_data,
    output logic [R-1:0]    gnt,
    output logic            cnt_load,
    output logic [31:0]     cnt_data,
    input  logic [5:0]      cnt_count,
    input  logic            cnt_done,
    output logic            res_valid,
    output logic [ID_W-1:0] res_id,
    output logic [5:0]      res_count,
    output logic            res_timeout,
    output logic            busy
);
    localparam int FLUSH_W = $clog2(ENGINE_N + 3);
    localparam int WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(ENGINE_N + 2);
    localparam logic [WD_W-1:0]    WD_LAST    = WD_W'(TIMEOUT - 1);
    localparam logic [ID_W-1:0]    LAST_ID    = ID_W'(R - 1);

    typedef enum logic [2:0] {
        S_FLUSH,
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_RESP
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [ID_W-1:0]    ptr;
    logic [ID_W-1:0]    win_q;
    logic [FLUSH_W-1:0] flush_cnt;
    logic [WD_W-1:0]    wd_cnt;
    logic               wd_expired;

    logic               lo_found;
    logic               hi_found;
    logic [ID_W-1:0]    lo_idx;
    logic [ID_W-1:0]    hi_idx;
    logic               pick_found;
    logic [ID_W-1:0]    pick_idx;
    logic [31:0]        pick_data;

    // Rotating priority: lowest requester at or above ptr, else lowest overall.
    always_comb begin
        lo_found = 1'b0;
        hi_found = 1'b0;
        lo_idx   = '0;
        hi_idx   = '0;
        for (int i = R - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo_found = 1'b1;
                lo_idx   = ID_W'(i);
            end
            if (req[i] && (ID_W'(i) >= ptr)) begin
                hi_found = 1'b1;
                hi_idx   = ID_W'(i);
            end
        end
        pick_found = lo_found;
        pick_idx   = hi_found ? hi_idx : lo_idx;
    end

    always_comb begin
        pick_data = '0;
        for (int i = 0; i < R; i++) begin
            if (pick_idx == ID_W'(i)) begin
                pick_data = req_data[32*i +: 32];
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        wd_expired = (wd_cnt == WD_LAST);
        gnt        = '0;
        cnt_load   = (state == S_LOAD);
        res_valid  = (state == S_RESP);
        busy       = (state != S_IDLE);
        for (int i = 0; i < R; i++) begin
            gnt[i] = (state == S_LOAD) && (win_q == ID_W'(i));
        end
        case (state)
            S_FLUSH: if (flush_cnt == FLUSH_LAST) state_nxt = S_IDLE;
            S_IDLE:  if (pick_found) state_nxt = S_LOAD;
            S_LOAD:  state_nxt = S_WAIT;
            S_WAIT:  if (cnt_done || wd_expired) state_nxt = S_RESP;
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_FLUSH;
        endcase
    end

    // The engine has no reset of its own, so FLUSH outlasts any job it may still be running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_FLUSH;
            flush_cnt   <= '0;
            wd_cnt      <= '0;
            ptr         <= '0;
            win_q       <= '0;
            cnt_data    <= '0;
            res_id      <= '0;
            res_count   <= '0;
            res_timeout <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                S_FLUSH: flush_cnt <= flush_cnt + 1'b1;
                S_IDLE: begin
                    if (pick_found) begin
                        win_q    <= pick_idx;
                        cnt_data <= pick_data;
                    end
                end
                S_LOAD: wd_cnt <= '0;
                S_WAIT: begin
                    wd_cnt <= wd_cnt + 1'b1;
                    // A done arriving in the expiry cycle still delivers the real count.
                    if (cnt_done) begin
                        res_id      <= win_q;
                        res_count   <= cnt_count;
                        res_timeout <= 1'b0;
                    end else if (wd_expired) begin
                        res_id      <= win_q;
                        res_count   <= '0;
                        res_timeout <= 1'b1;
                    end
                end
                S_RESP: ptr <= (win_q == LAST_ID) ? '0 : win_q + 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_popcount_scheduler.sv
// tb/tb_popcount_scheduler.sv - scoreboard bench for popcount_scheduler with a serial engine model
`timescale 1ns/1ps
module tb_popcount_scheduler;
    localparam int R        = 4;
    localparam int ID_W     = 2;
    localparam int ENGINE_N = 32;
    localparam int TIMEOUT  = 64;
    localparam int LAT      = ENGINE_N + 2;
    localparam int PITCH    = ENGINE_N + 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [R-1:0]    req = '0;
    logic [32*R-1:0] req_data = '0;
    logic [R-1:0]    gnt;
    logic            cnt_load;
    logic [31:0]     cnt_data;
    logic [5:0]      cnt_count;
    logic            cnt_done;
    logic            res_valid;
    logic [ID_W-1:0] res_id;
    logic [5:0]      res_count;
    logic            res_timeout;
    logic            busy;

    popcount_scheduler #(.R(R), .ID_W(ID_W), .ENGINE_N(ENGINE_N), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .gnt(gnt),
        .cnt_load(cnt_load), .cnt_data(cnt_data), .cnt_count(cnt_count), .cnt_done(cnt_done),
        .res_valid(res_valid), .res_id(res_id), .res_count(res_count),
        .res_timeout(res_timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // serial engine: one bit per clock, done after ENGINE_N shifts, no reset
    logic [31:0] eng_sh = '0;
    logic [5:0]  eng_cnt = '0;
    int          eng_left = 0;
    logic        eng_done = 1'b0;
    logic        eng_dead = 1'b0;
    always @(posedge clk) begin
        if (cnt_load) begin
            eng_sh   <= cnt_data;
            eng_cnt  <= '0;
            eng_left <= ENGINE_N;
            eng_done <= 1'b0;
        end else if (eng_left > 0) begin
            eng_cnt  <= eng_cnt + {5'd0, eng_sh[0]};
            eng_sh   <= eng_sh >> 1;
            eng_left <= eng_left - 1;
            if (eng_left == 1) eng_done <= 1'b1;
        end
    end
    assign cnt_done  = eng_done && !eng_dead;
    assign cnt_count = eng_cnt;

    typedef struct {
        int id;
        int count;
        bit to;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;
    int checks = 0;
    int errors = 0;

    always @(negedge clk) begin
        if (rst_n && res_valid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result got id=%0d count=%0d to=%0b expected no result",
                         res_id, res_count, res_timeout);
            end else begin
                mon_e = sb.pop_front();
                if (res_id !== ID_W'(mon_e.id) || res_count !== 6'(mon_e.count) || res_timeout !== mon_e.to) begin
                    errors++;
                    $display("FAIL result got id=%0d count=%0d to=%0b expected id=%0d count=%0d to=%0b",
                             res_id, res_count, res_timeout, mon_e.id, mon_e.count, mon_e.to);
                end
            end
        end
    end

    task automatic push_exp(input int id, input logic [31:0] op, input bit to);
        exp_t e;
        e.id = id;
        e.count = to ? 0 : $countones(op);
        e.to = to;
        sb.push_back(e);
    endtask

    task automatic set_lane(input int i, input logic [31:0] v);
        req_data[32*i +: 32] = v;
    endtask

    task automatic wait_gnt(output logic [R-1:0] g, output int at, output bit ok);
        int n;
        ok = 1'b0; g = '0; at = 0; n = 0;
        while (!ok && n < 200) begin
            @(negedge clk);
            n++;
            if (gnt !== '0) begin ok = 1'b1; g = gnt; at = cyc; end
        end
    endtask

    task automatic wait_res(output int at, output bit ok);
        int n;
        ok = 1'b0; at = 0; n = 0;
        while (!ok && n < 200) begin
            @(negedge clk);
            n++;
            if (res_valid === 1'b1) begin ok = 1'b1; at = cyc; end
        end
    endtask

    task automatic drain(output bit ok);
        int n;
        ok = 1'b0; n = 0;
        while (!ok && n < 200) begin
            @(negedge clk);
            n++;
            if (sb.size() == 0 && busy === 1'b0) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        int bad;
        rst_n = 1'b0;
        req = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({gnt, cnt_load, cnt_data, res_valid, res_id, res_count, res_timeout} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got gnt=%b load=%b data=%h valid=%b id=%0d count=%0d to=%b expected all 0",
                     gnt, cnt_load, cnt_data, res_valid, res_id, res_count, res_timeout);
        end
        rst_n = 1'b1;
        bad = 0;
        for (int k = 0; k < ENGINE_N + 2; k++) begin
            @(negedge clk);
            if (busy !== 1'b1 || gnt !== '0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL flush_hold got %0d bad cycles expected 0", bad);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_exit got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_contention();
        int ids[5] = '{0, 1, 2, 3, 0};
        logic [R-1:0] g;
        int at, prev;
        bit ok;
        set_lane(0, 32'h0000_0000);
        set_lane(1, 32'h0000_0001);
        set_lane(2, 32'h8000_0001);
        set_lane(3, 32'hFFFF_FFFF);
        push_exp(0, 32'h0000_0000, 1'b0);
        push_exp(1, 32'h0000_0001, 1'b0);
        push_exp(2, 32'h8000_0001, 1'b0);
        push_exp(3, 32'hFFFF_FFFF, 1'b0);
        push_exp(0, 32'h0000_0000, 1'b0);
        req = 4'b1111;
        prev = 0;
        for (int j = 0; j < 5; j++) begin
            wait_gnt(g, at, ok);
            checks++;
            if (!ok || g !== (R'(1) << ids[j])) begin
                errors++;
                $display("FAIL contention_gnt%0d got %b expected %b", j, g, R'(1) << ids[j]);
            end
            if (j > 0) begin
                checks++;
                if (at - prev != PITCH) begin
                    errors++;
                    $display("FAIL contention_pitch%0d got %0d expected %0d", j, at - prev, PITCH);
                end
            end
            prev = at;
        end
        req = '0;
        drain(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL contention_drain got pending=%0d expected 0", sb.size()); end
    endtask

    task automatic test_pointer_wrap();
        logic [R-1:0] g;
        int at;
        bit ok;
        set_lane(3, 32'h0000_00FF);
        push_exp(3, 32'h0000_00FF, 1'b0);
        req = 4'b1000;
        wait_gnt(g, at, ok);
        checks++;
        if (!ok || g !== 4'b1000) begin errors++; $display("FAIL wrap_first got %b expected 1000", g); end
        req = '0;
        drain(ok);
        set_lane(0, 32'h0F0F_0F0F);
        set_lane(3, 32'h0000_0001);
        push_exp(0, 32'h0F0F_0F0F, 1'b0);
        push_exp(3, 32'h0000_0001, 1'b0);
        req = 4'b1001;
        wait_gnt(g, at, ok);
        checks++;
        if (!ok || g !== 4'b0001) begin errors++; $display("FAIL wrap_pick got %b expected 0001", g); end
        req = 4'b1000;
        wait_gnt(g, at, ok);
        checks++;
        if (!ok || g !== 4'b1000) begin errors++; $display("FAIL wrap_next got %b expected 1000", g); end
        req = '0;
        drain(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL wrap_drain got pending=%0d expected 0", sb.size()); end
    endtask

    task automatic test_single();
        logic [R-1:0] g;
        int at_g, at_r;
        bit ok;
        set_lane(0, 32'hFFFF_0000);
        push_exp(0, 32'hFFFF_0000, 1'b0);
        req = 4'b0001;
        wait_gnt(g, at_g, ok);
        checks++;
        if (!ok || g !== 4'b0001 || cnt_load !== 1'b1 || cnt_data !== 32'hFFFF_0000) begin
            errors++;
            $display("FAIL single_load got gnt=%b load=%b data=%h expected 0001 1 ffff0000", g, cnt_load, cnt_data);
        end
        req = '0;
        @(negedge clk);
        checks++;
        if (gnt !== '0 || cnt_load !== 1'b0) begin
            errors++;
            $display("FAIL single_pulse got gnt=%b load=%b expected 0000 0", gnt, cnt_load);
        end
        wait_res(at_r, ok);
        checks++;
        if (!ok || at_r - at_g != LAT) begin
            errors++;
            $display("FAIL single_latency got %0d expected %0d", at_r - at_g, LAT);
        end
        drain(ok);
    endtask

    task automatic test_watchdog();
        logic [R-1:0] g;
        int at_g, at_r;
        bit ok;
        eng_dead = 1'b1;
        set_lane(1, 32'h0000_0007);
        push_exp(1, 32'h0000_0007, 1'b1);
        req = 4'b0010;
        wait_gnt(g, at_g, ok);
        req = '0;
        wait_res(at_r, ok);
        checks++;
        if (!ok || at_r - at_g != TIMEOUT + 1) begin
            errors++;
            $display("FAIL watchdog_latency got %0d expected %0d", at_r - at_g, TIMEOUT + 1);
        end
        drain(ok);
        eng_dead = 1'b0;
        push_exp(1, 32'h0000_0007, 1'b0);
        req = 4'b0010;
        wait_gnt(g, at_g, ok);
        checks++;
        if (!ok || g !== 4'b0010) begin errors++; $display("FAIL watchdog_next_gnt got %b expected 0010", g); end
        req = '0;
        wait_res(at_r, ok);
        checks++;
        if (!ok || at_r - at_g != LAT) begin
            errors++;
            $display("FAIL watchdog_next_latency got %0d expected %0d", at_r - at_g, LAT);
        end
        drain(ok);
    endtask

    task automatic test_back_to_back();
        logic [R-1:0] g1, g2;
        int at1, at2;
        bit ok1, ok2, ok;
        set_lane(2, 32'h0000_0000);
        push_exp(2, 32'h0000_0000, 1'b0);
        push_exp(2, 32'hFFFF_FFFF, 1'b0);
        req = 4'b0100;
        wait_gnt(g1, at1, ok1);
        set_lane(2, 32'hFFFF_FFFF);
        wait_gnt(g2, at2, ok2);
        req = '0;
        checks++;
        if (!ok1 || !ok2 || g1 !== 4'b0100 || g2 !== 4'b0100) begin
            errors++;
            $display("FAIL b2b_gnt got %b %b expected 0100 0100", g1, g2);
        end
        checks++;
        if (at2 - at1 != PITCH) begin
            errors++;
            $display("FAIL b2b_pitch got %0d expected %0d", at2 - at1, PITCH);
        end
        drain(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL b2b_drain got pending=%0d expected 0", sb.size()); end
    endtask

    task automatic test_reset_mid_wait();
        logic [R-1:0] g;
        int at_g, at_r, bad;
        bit ok;
        set_lane(1, 32'h0000_FFFF);
        req = 4'b0010;
        wait_gnt(g, at_g, ok);
        req = '0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({gnt, cnt_load, cnt_data, res_valid, res_id, res_count, res_timeout} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs got gnt=%b load=%b data=%h valid=%b id=%0d count=%0d to=%b expected all 0",
                     gnt, cnt_load, cnt_data, res_valid, res_id, res_count, res_timeout);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int k = 0; k < ENGINE_N + 2; k++) begin
            @(negedge clk);
            if (busy !== 1'b1 || gnt !== '0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL midreset_flush got %0d bad cycles expected 0", bad); end
        set_lane(1, 32'h1234_5678);
        push_exp(1, 32'h1234_5678, 1'b0);
        req = 4'b0010;
        wait_gnt(g, at_g, ok);
        checks++;
        if (!ok || g !== 4'b0010) begin errors++; $display("FAIL midreset_gnt got %b expected 0010", g); end
        req = '0;
        wait_res(at_r, ok);
        checks++;
        if (!ok || at_r - at_g != LAT) begin
            errors++;
            $display("FAIL midreset_latency got %0d expected %0d", at_r - at_g, LAT);
        end
        drain(ok);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout got no finish expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        test_reset();
        test_contention();
        test_pointer_wrap();
        test_single();
        test_watchdog();
        test_back_to_back();
        test_reset_mid_wait();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_empty got %0d pending expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
